// File: rtl/apu_unit_if.sv
// Bundle of loop-increment stream, packed formula inputs, selector and the
// selected APU's outputs shared between the loop controller and apu_unit.
interface apu_unit_if #(
  parameter int BITS         = 8,
  parameter int LOG_LOOP_CNT = 1,
  parameter int LOG_APU_CNT  = 1
);
  localparam int LOOP_CNT = 1 << LOG_LOOP_CNT;
  localparam int APU_CNT  = 1 << LOG_APU_CNT;
  localparam int FW       = (LOOP_CNT + 1) * BITS * APU_CNT;

  logic [BITS-1:0]         di;
  logic [FW-1:0]           new_address_formula;
  logic [FW-1:0]           new_stride_x_formula;
  logic [FW-1:0]           new_stride_y_formula;
  logic                    change_loop_var;
  logic [LOG_LOOP_CNT-1:0] loop_var;
  logic [LOG_APU_CNT-1:0]  apu_selector;
  logic [BITS-1:0]         addr;
  logic [BITS-1:0]         stridex;
  logic [BITS-1:0]         stridey;
  logic [BITS-1:0]         daddr;
  logic [BITS-1:0]         dstridex;
  logic [BITS-1:0]         dstridey;

  modport master (
    output di, new_address_formula, new_stride_x_formula, new_stride_y_formula,
    output change_loop_var, loop_var, apu_selector,
    input  addr, stridex, stridey, daddr, dstridex, dstridey
  );

  modport slave (
    input  di, new_address_formula, new_stride_x_formula, new_stride_y_formula,
    input  change_loop_var, loop_var, apu_selector,
    output addr, stridex, stridey, daddr, dstridex, dstridey
  );
endinterface

// File: rtl/apu_unit.sv
// Bank of affine address generators: each APU accumulates coef[active loop]*di
// for its address, stride-x and stride-y formulas; one APU is muxed to the outputs.
module apu_unit #(
  parameter int BITS         = 8,
  parameter int LOG_LOOP_CNT = 1,
  parameter int LOG_APU_CNT  = 1
) (
  input logic       clk,
  input logic       reset,
  apu_unit_if.slave bus
);
  localparam int LOOP_CNT     = 1 << LOG_LOOP_CNT;
  localparam int APU_CNT      = 1 << LOG_APU_CNT;
  localparam int SLICE        = (LOOP_CNT + 1) * BITS;
  localparam int NUM_FORMULAS = 3;

  // Field 0 of each unpacked formula is the base, fields 1.. are per-loop coefficients.
  logic [BITS-1:0] new_field [APU_CNT][NUM_FORMULAS][LOOP_CNT+1];

  logic [BITS-1:0] coef_tbl_q [APU_CNT][NUM_FORMULAS][LOOP_CNT];
  logic [BITS-1:0] coef_q     [APU_CNT][NUM_FORMULAS];
  logic [BITS-1:0] acc_q      [APU_CNT][NUM_FORMULAS];
  logic [BITS-1:0] di_q;
  logic [LOG_LOOP_CNT-1:0] sel_q;

  // APU 0 sits in the most significant slice of each packed formula bus.
  for (genvar k = 0; k < APU_CNT; k++) begin : g_apu
    for (genvar f = 0; f <= LOOP_CNT; f++) begin : g_field
      assign new_field[k][0][f] = bus.new_address_formula[SLICE*(APU_CNT-1-k) + BITS*f +: BITS];
      assign new_field[k][1][f] = bus.new_stride_x_formula[SLICE*(APU_CNT-1-k) + BITS*f +: BITS];
      assign new_field[k][2][f] = bus.new_stride_y_formula[SLICE*(APU_CNT-1-k) + BITS*f +: BITS];
    end
  end

  // coef_q is loaded from the previously selected loop, so a loop change takes
  // one extra edge to reach the accumulators while increments in flight still use the old coef.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      di_q  <= '0;
      for (int k = 0; k < APU_CNT; k++) begin
        for (int m = 0; m < NUM_FORMULAS; m++) begin
          acc_q[k][m]  <= new_field[k][m][0];
          coef_q[k][m] <= '0;
          for (int l = 0; l < LOOP_CNT; l++) begin
            coef_tbl_q[k][m][l] <= new_field[k][m][l+1];
          end
        end
      end
    end else begin
      if (bus.change_loop_var) begin
        sel_q <= bus.loop_var;
      end
      di_q <= bus.di;
      for (int k = 0; k < APU_CNT; k++) begin
        for (int m = 0; m < NUM_FORMULAS; m++) begin
          coef_q[k][m] <= coef_tbl_q[k][m][sel_q];
          acc_q[k][m]  <= acc_q[k][m] + coef_q[k][m] * di_q;
        end
      end
    end
  end

  assign bus.addr     = acc_q[bus.apu_selector][0];
  assign bus.stridex  = acc_q[bus.apu_selector][1];
  assign bus.stridey  = acc_q[bus.apu_selector][2];
  assign bus.daddr    = coef_q[bus.apu_selector][0];
  assign bus.dstridex = coef_q[bus.apu_selector][1];
  assign bus.dstridey = coef_q[bus.apu_selector][2];
endmodule

// File: tb/tb_apu_unit.sv
// Self-checking bench for apu_unit: directed vectors with literal pins plus a
// per-cycle comparison against an arithmetic model of the affine accumulators.
module tb_apu_unit;
  localparam int BITS  = 8;
  localparam int SLICE = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  apu_unit_if #(.BITS(8), .LOG_LOOP_CNT(1), .LOG_APU_CNT(1)) bus ();

  apu_unit #(.BITS(8), .LOG_LOOP_CNT(1), .LOG_APU_CNT(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // fa[apu][formula][field]: field 0 base, field 1+l coef for loop l
  logic [7:0] fa [2][3][3];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setFormula(input int apu, input int form, input int base, input int c0, input int c1);
    fa[apu][form][0] = 8'(base);
    fa[apu][form][1] = 8'(c0);
    fa[apu][form][2] = 8'(c1);
  endtask

  task automatic packFormulas();
    for (int a = 0; a < 2; a++) begin
      for (int f = 0; f < 3; f++) begin
        bus.new_address_formula[SLICE*(1-a) + 8*f +: 8]  = fa[a][0][f];
        bus.new_stride_x_formula[SLICE*(1-a) + 8*f +: 8] = fa[a][1][f];
        bus.new_stride_y_formula[SLICE*(1-a) + 8*f +: 8] = fa[a][2][f];
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic ch, input logic lv, input logic s);
    bus.di              = d;
    bus.change_loop_var = ch;
    bus.loop_var        = lv;
    bus.apu_selector    = s;
    cycle();
  endtask

  // Model: di sampled at an edge is worth coef[loop selected before that edge]*di
  // and lands in the accumulator one edge later; the visible coef is that same coef.
  int m_f    [2][3][3];
  int m_acc  [2][3];
  int m_pend [2][3];
  int m_dco  [2][3];
  int m_loop;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      for (int a = 0; a < 2; a++) begin
        for (int f = 0; f < 3; f++) begin
          for (int x = 0; x < 3; x++) m_f[a][f][x] = int'(fa[a][f][x]);
          m_acc[a][f]  = m_f[a][f][0];
          m_pend[a][f] = 0;
          m_dco[a][f]  = 0;
        end
      end
      m_loop  = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int a = 0; a < 2; a++) begin
        for (int f = 0; f < 3; f++) begin
          m_acc[a][f]  = (m_acc[a][f] + m_pend[a][f]) % 256;
          m_dco[a][f]  = m_f[a][f][1 + m_loop];
          m_pend[a][f] = m_dco[a][f] * int'(bus.di);
        end
      end
      if (bus.change_loop_var) m_loop = int'(bus.loop_var);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int s;
      s = int'(bus.apu_selector);
      checkOutput("model_addr",     bus.addr,     8'(m_acc[s][0]));
      checkOutput("model_stridex",  bus.stridex,  8'(m_acc[s][1]));
      checkOutput("model_stridey",  bus.stridey,  8'(m_acc[s][2]));
      checkOutput("model_daddr",    bus.daddr,    8'(m_dco[s][0]));
      checkOutput("model_dstridex", bus.dstridex, 8'(m_dco[s][1]));
      checkOutput("model_dstridey", bus.dstridey, 8'(m_dco[s][2]));
    end
  end

  int di_tab [16] = '{7, 0, 250, 13, 0, 99, 1, 255, 42, 0, 17, 3, 128, 64, 5, 200};
  int ch_tab [16] = '{0, 1, 0,   0,  1, 0,  0, 1,   0,  0, 1,  0, 1,   0,  0, 1};
  int lv_tab [16] = '{0, 1, 0,   0,  0, 0,  0, 1,   0,  0, 1,  0, 1,   0,  0, 0};

  initial begin
    setFormula(0, 0, 0, 1, 2);
    setFormula(1, 0, 0, 3, 4);
    setFormula(0, 1, 1, 1, 1);
    setFormula(1, 1, 2, 0, 5);
    setFormula(0, 2, 0, 2, 3);
    setFormula(1, 2, 7, 1, 1);
    packFormulas();
    reset               = 1'b1;
    bus.di              = 8'd0;
    bus.change_loop_var = 1'b1;
    bus.loop_var        = 1'b0;
    bus.apu_selector    = 1'b0;
    cycle();
    reset               = 1'b0;
    bus.change_loop_var = 1'b0;

    checkOutput("rst_addr0", bus.addr, 8'd0);
    checkOutput("rst_daddr0", bus.daddr, 8'd0);
    checkOutput("rst_stridex0", bus.stridex, 8'd1);
    bus.apu_selector = 1'b1;
    #1;
    checkOutput("rst_addr1", bus.addr, 8'd0);
    checkOutput("rst_stridex1", bus.stridex, 8'd2);
    bus.apu_selector = 1'b0;

    // single di=1 pulse reaches the accumulators one edge late
    bus.di = 8'd1;
    cycle();
    bus.di = 8'd0;
    checkOutput("di1_addr_e1", bus.addr, 8'd0);
    checkOutput("di1_daddr_e1", bus.daddr, 8'd1);
    cycle();
    checkOutput("di1_addr0", bus.addr, 8'd1);
    bus.apu_selector = 1'b1;
    #1;
    checkOutput("di1_addr1", bus.addr, 8'd3);
    bus.apu_selector = 1'b0;

    // loop switch with di=2 held: old coef still applies for one edge
    bus.di = 8'd2;
    cycle();
    checkOutput("sw_addr_f0", bus.addr, 8'd1);
    bus.change_loop_var = 1'b1;
    bus.loop_var        = 1'b1;
    cycle();
    bus.change_loop_var = 1'b0;
    checkOutput("sw_addr0_f1", bus.addr, 8'd3);
    bus.apu_selector = 1'b1;
    #1;
    checkOutput("sw_addr1_f1", bus.addr, 8'd9);
    bus.apu_selector = 1'b0;
    cycle();
    checkOutput("sw_addr0_f2", bus.addr, 8'd5);
    checkOutput("sw_daddr0_f2", bus.daddr, 8'd2);
    bus.apu_selector = 1'b1;
    #1;
    checkOutput("sw_addr1_f2", bus.addr, 8'd15);
    bus.apu_selector = 1'b0;
    cycle();
    checkOutput("sw_addr0_f3", bus.addr, 8'd9);
    bus.apu_selector = 1'b1;
    #1;
    checkOutput("sel_addr1_now", bus.addr, 8'd23);
    checkOutput("sel_daddr1_now", bus.daddr, 8'd4);
    cycle();
    checkOutput("sel_addr1_next", bus.addr, 8'd31);

    // new formulas and a reset while increments are in flight
    setFormula(0, 0, 16, 200, 7);
    setFormula(1, 0, 100, 50, 9);
    setFormula(0, 1, 30, 2, 1);
    setFormula(1, 1, 40, 4, 3);
    setFormula(0, 2, 50, 6, 5);
    setFormula(1, 2, 60, 128, 250);
    packFormulas();
    bus.di           = 8'd5;
    bus.apu_selector = 1'b0;
    reset            = 1'b1;
    cycle();
    reset  = 1'b0;
    bus.di = 8'd3;
    checkOutput("rr_addr0", bus.addr, 8'd16);
    checkOutput("rr_stridex0", bus.stridex, 8'd30);
    checkOutput("rr_stridey0", bus.stridey, 8'd50);
    checkOutput("rr_daddr0", bus.daddr, 8'd0);
    checkOutput("rr_dstridex0", bus.dstridex, 8'd0);
    bus.apu_selector = 1'b1;
    #1;
    checkOutput("rr_addr1", bus.addr, 8'd100);
    checkOutput("rr_stridey1", bus.stridey, 8'd60);
    bus.apu_selector = 1'b0;
    cycle();
    bus.di = 8'd0;
    checkOutput("rr_addr0_g1", bus.addr, 8'd16);
    checkOutput("rr_daddr0_g1", bus.daddr, 8'd200);
    checkOutput("rr_dstridex0_g1", bus.dstridex, 8'd2);
    checkOutput("rr_dstridey0_g1", bus.dstridey, 8'd6);
    cycle();
    checkOutput("wrap_addr0", bus.addr, 8'd104);
    checkOutput("wrap_stridex0", bus.stridex, 8'd36);
    checkOutput("wrap_stridey0", bus.stridey, 8'd68);
    bus.apu_selector = 1'b1;
    #1;
    checkOutput("wrap_addr1", bus.addr, 8'd250);
    checkOutput("wrap_stridey1", bus.stridey, 8'd188);
    bus.apu_selector = 1'b0;
    cycle();
    checkOutput("hold_addr0", bus.addr, 8'd104);

    // directed table, including a reset with change_loop_var asserted
    for (int i = 0; i < 16; i++) begin
      reset = (i == 10);
      applyStimulus(8'(di_tab[i]), ch_tab[i] != 0, 1'(lv_tab[i]), 1'(i % 2));
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'd0, 1'b0, 1'b0, 1'(i % 2));

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
